// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types and constants for the branch resolve unit and its queue.
//   state_e     : resolve FSM states (RUN accepts traffic, FLUSH recovers)
//   PC_INC      : sequential fall-through increment
//   BP_PC_W     : default PC width used by the predictor interface
//   bp_entry_t  : one queued prediction at the default PC width
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int unsigned BP_PC_W = 33;
    localparam int unsigned PC_INC  = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic [BP_PC_W-1:0] pred_next;
    } bp_entry_t;

endpackage

// File: rtl/bp_fifo.sv
// ---------------------------------------------------------------------------
// bp_fifo
// Synchronous circular FIFO holding outstanding predictions in fetch order.
// Pointers carry one extra wrap bit so full and empty stay distinct when the
// address bits coincide.
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous, active-high reset (pointers only)
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   entry to write
//   pop        in   advance the head (ignored when empty)
//   clear      in   discard all entries; overrides push and pop
//   full       out  no free entry
//   empty      out  no valid entry
//   head       out  oldest entry (undefined while empty)
// ---------------------------------------------------------------------------
module bp_fifo #(
    parameter int unsigned W     = 66,
    parameter int unsigned DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         clear,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    // NOTE: every signal assigned in an always_comb gets a default on the
    // first lines of the block so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            // Catch the head up to the tail instead of zeroing both, so the
            // storage keeps rotating through every slot.
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push && !full)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop && !empty)
                rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; pointers alone define validity,
    // and leaving it unreset lets it map onto plain RAM/flop arrays.
    always_ff @(posedge Clk) begin
        if (push && !full && !clear)
            mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Queues fetch-stage predictions in order, checks each against the outcome
// EX reports for the oldest instruction, and on a mispredict issues a
// registered one-cycle Flush with the correct RedirectPC. Keeps saturating
// branch / mispredict statistics and a sticky protocol error flag.
//   Clk           in   clock, rising edge
//   Reset         in   asynchronous, active-high reset
//   PredValid     in   fetch presents a prediction
//   PredPC        in   PC of the fetched instruction
//   PredNextPC    in   predicted next PC
//   PredReady     out  prediction accepted when PredValid & PredReady
//   ResValid      in   EX resolves the oldest outstanding instruction
//   ResIsBranch   in   resolved instruction is a branch/jump
//   ResTaken      in   branch taken
//   ResTarget     in   taken target
//   Flush         out  one-cycle squash pulse
//   RedirectPC    out  correct next PC, valid while Flush=1
//   BranchCount   out  resolved branches, saturating
//   MispredCount  out  mispredicts, saturating
//   ProtoErr      out  sticky: resolve seen with an empty queue
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int unsigned PC_W         = BP_PC_W,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PredValid,
    input  logic [PC_W-1:0]  PredPC,
    input  logic [PC_W-1:0]  PredNextPC,
    output logic             PredReady,
    input  logic             ResValid,
    input  logic             ResIsBranch,
    input  logic             ResTaken,
    input  logic [PC_W-1:0]  ResTarget,
    output logic             Flush,
    output logic [PC_W-1:0]  RedirectPC,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredCount,
    output logic             ProtoErr
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    // Same layout as bp_entry_t, sized by this instance's PC width.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_next;
    } entry_t;

    state_e           state_q, state_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             flush_q, flush_d;
    logic [PC_W-1:0]  redirect_q, redirect_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
    logic             proto_q, proto_d;

    entry_t           push_entry;
    entry_t           head_entry;
    logic             q_full, q_empty;

    logic             accept_push;
    logic             resolve;
    logic             mispredict;
    logic [PC_W-1:0]  actual_next;

    assign push_entry = '{pc: PredPC, pred_next: PredNextPC};

    // Ready depends on registered state only: a pop in the same cycle does
    // not open a slot for a push while full.
    assign PredReady   = (state_q == RUN) && !q_full;
    assign accept_push = PredValid && PredReady;
    assign resolve     = (state_q == RUN) && ResValid && !q_empty;

    // Fall-through addition wraps modulo 2^PC_W.
    assign actual_next = (ResIsBranch && ResTaken) ? ResTarget
                                                   : head_entry.pc + PC_W'(PC_INC);
    assign mispredict  = resolve && (actual_next != head_entry.pred_next);

    bp_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (accept_push && !mispredict),
        .push_data (push_entry),
        .pop       (resolve && !mispredict),
        .clear     (mispredict),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head_entry)
    );

    // FSM next state and flush pulse.
    always_comb begin
        state_d    = state_q;
        fc_d       = fc_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        unique case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d    = FLUSH;
                    fc_d       = FC_W'(FLUSH_CYCLES - 1);
                    flush_d    = 1'b1;
                    redirect_d = actual_next;
                end
            end
            FLUSH: begin
                if (fc_q == '0)
                    state_d = RUN;
                else
                    fc_d = fc_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // Statistics and protocol flag.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        proto_d  = proto_q;
        if (resolve && ResIsBranch && (br_cnt_q != '1))
            br_cnt_d = br_cnt_q + CNT_W'(1);
        if (mispredict && (mp_cnt_q != '1))
            mp_cnt_d = mp_cnt_q + CNT_W'(1);
        // Only RUN can flag an empty-queue resolve; FLUSH ignores ResValid.
        if ((state_q == RUN) && ResValid && q_empty)
            proto_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= RUN;
            fc_q       <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            br_cnt_q   <= '0;
            mp_cnt_q   <= '0;
            proto_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fc_q       <= fc_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            br_cnt_q   <= br_cnt_d;
            mp_cnt_q   <= mp_cnt_d;
            proto_q    <= proto_d;
        end
    end

    assign Flush        = flush_q;
    assign RedirectPC   = redirect_q;
    assign BranchCount  = br_cnt_q;
    assign MispredCount = mp_cnt_q;
    assign ProtoErr     = proto_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit. Counters are instantiated 4 bits
// wide so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int unsigned PC_W  = 33;
    localparam int unsigned CNT_W = 4;

    logic             Clk;
    logic             Reset;
    logic             PredValid;
    logic [PC_W-1:0]  PredPC;
    logic [PC_W-1:0]  PredNextPC;
    logic             PredReady;
    logic             ResValid;
    logic             ResIsBranch;
    logic             ResTaken;
    logic [PC_W-1:0]  ResTarget;
    logic             Flush;
    logic [PC_W-1:0]  RedirectPC;
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] MispredCount;
    logic             ProtoErr;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mp = 0;

    branch_resolve_unit #(
        .PC_W         (PC_W),
        .DEPTH        (4),
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PredValid    (PredValid),
        .PredPC       (PredPC),
        .PredNextPC   (PredNextPC),
        .PredReady    (PredReady),
        .ResValid     (ResValid),
        .ResIsBranch  (ResIsBranch),
        .ResTaken     (ResTaken),
        .ResTarget    (ResTarget),
        .Flush        (Flush),
        .RedirectPC   (RedirectPC),
        .BranchCount  (BranchCount),
        .MispredCount (MispredCount),
        .ProtoErr     (ProtoErr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic pv, input logic [PC_W-1:0] ppc, input logic [PC_W-1:0] pnx,
                        input logic rv, input logic rb, input logic rt,
                        input logic [PC_W-1:0] rtgt);
        PredValid   = pv;
        PredPC      = ppc;
        PredNextPC  = pnx;
        ResValid    = rv;
        ResIsBranch = rb;
        ResTaken    = rt;
        ResTarget   = rtgt;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] nx);
        step(1'b1, pc, nx, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic rb, input logic rt, input logic [PC_W-1:0] tgt);
        step(1'b0, '0, '0, 1'b1, rb, rt, tgt);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_br"}, 64'(BranchCount), 64'(exp_br));
        check({tag, "_mp"}, 64'(MispredCount), 64'(exp_mp));
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    initial begin
        Reset = 1'b1;
        PredValid = 1'b0; PredPC = '0; PredNextPC = '0;
        ResValid = 1'b0; ResIsBranch = 1'b0; ResTaken = 1'b0; ResTarget = '0;
        #12;
        Reset = 1'b0;

        // T1: reset in the middle of a flush pulse.
        push(33'h10, 33'h20);
        resolve(1'b0, 1'b0, '0);               // 0x14 != 0x20
        check("t1_pre_flush", 64'(Flush), 64'd1);
        check("t1_pre_redir", 64'(RedirectPC), 64'h14);
        Reset = 1'b1;
        #1;
        check("t1_rst_flush", 64'(Flush), 64'd0);
        check("t1_rst_redir", 64'(RedirectPC), 64'd0);
        check("t1_rst_proto", 64'(ProtoErr), 64'd0);
        check_counts("t1_rst");
        #2;
        Reset = 1'b0;
        idle();
        check("t1_ready", 64'(PredReady), 64'd1);
        check("t1_no_pulse", 64'(Flush), 64'd0);

        // T2: correct predictions; push and resolve in the same cycle.
        push(33'h100, 33'h104);
        check("t2_ready", 64'(PredReady), 64'd1);
        step(1'b1, 33'h104, 33'h108, 1'b1, 1'b0, 1'b0, '0);
        check("t2_nb_flush", 64'(Flush), 64'd0);
        check_counts("t2_nb");
        resolve(1'b1, 1'b0, 33'h999);          // not taken: 0x108
        exp_br = sat_inc(exp_br);
        check("t2_nt_flush", 64'(Flush), 64'd0);
        check("t2_nt_proto", 64'(ProtoErr), 64'd0);
        check_counts("t2_nt");

        // T3: mispredict, same-cycle push dropped, ResValid ignored in FLUSH.
        push(33'h200, 33'h204);
        push(33'h204, 33'h208);
        step(1'b1, 33'h208, 33'h20C, 1'b1, 1'b1, 1'b1, 33'h300);
        exp_br = sat_inc(exp_br);
        exp_mp = sat_inc(exp_mp);
        check("t3_flush", 64'(Flush), 64'd1);
        check("t3_redir", 64'(RedirectPC), 64'h300);
        check("t3_ready0", 64'(PredReady), 64'd0);
        check_counts("t3_mp");
        resolve(1'b1, 1'b0, '0);               // FLUSH: ignored
        check("t3_pulse_end", 64'(Flush), 64'd0);
        check("t3_ready1", 64'(PredReady), 64'd0);
        check("t3_fl_proto", 64'(ProtoErr), 64'd0);
        check_counts("t3_fl");
        idle();
        check("t3_ready_run", 64'(PredReady), 64'd1);

        // T6: queue must be empty now, so this resolve is a protocol error.
        resolve(1'b1, 1'b0, '0);
        check("t6_proto", 64'(ProtoErr), 64'd1);
        check("t6_flush", 64'(Flush), 64'd0);
        check_counts("t6_empty");
        idle();
        check("t6_sticky", 64'(ProtoErr), 64'd1);

        // T4: fill, full + resolve, order across pointer wrap.
        push(33'h400, 33'h500);
        push(33'h404, 33'h600);
        push(33'h408, 33'h700);
        check("t4_ready3", 64'(PredReady), 64'd1);
        push(33'h40C, 33'h800);
        check("t4_full", 64'(PredReady), 64'd0);
        step(1'b1, 33'h410, 33'h900, 1'b1, 1'b1, 1'b1, 33'h500);
        exp_br = sat_inc(exp_br);
        check("t4_simul_flush", 64'(Flush), 64'd0);
        check("t4_ready_after", 64'(PredReady), 64'd1);
        push(33'h410, 33'h900);
        check("t4_full2", 64'(PredReady), 64'd0);
        resolve(1'b1, 1'b1, 33'h600);
        check("t4_ord1", 64'(Flush), 64'd0);
        resolve(1'b1, 1'b1, 33'h700);
        check("t4_ord2", 64'(Flush), 64'd0);
        resolve(1'b1, 1'b1, 33'h800);
        check("t4_ord3", 64'(Flush), 64'd0);
        resolve(1'b1, 1'b1, 33'h900);
        check("t4_ord4", 64'(Flush), 64'd0);
        exp_br = exp_br + 4;
        check_counts("t4_end");

        // T5: fall-through wraps modulo 2^33.
        push(33'h1_FFFF_FFFC, 33'h0);
        resolve(1'b1, 1'b0, 33'h123);
        exp_br = sat_inc(exp_br);
        check("t5_wrap_flush", 64'(Flush), 64'd0);
        check_counts("t5_wrap");

        // Non-branch mispredict: counts as mispredict only.
        push(33'h1000, 33'h2000);
        resolve(1'b0, 1'b0, '0);
        exp_mp = sat_inc(exp_mp);
        check("nb_mp_flush", 64'(Flush), 64'd1);
        check("nb_mp_redir", 64'(RedirectPC), 64'h1004);
        check_counts("nb_mp");
        idle();
        idle();

        // Saturation of BranchCount.
        for (int i = 0; i < 10; i++) begin
            push(33'h2000 + 33'(i * 8), 33'h2004 + 33'(i * 8));
            resolve(1'b1, 1'b0, '0);
            exp_br = sat_inc(exp_br);
        end
        check("sat_br_flush", 64'(Flush), 64'd0);
        check_counts("sat_br");

        // Saturation of MispredCount.
        for (int i = 0; i < 15; i++) begin
            push(33'h3000 + 33'(i * 16), 33'h3008 + 33'(i * 16));
            resolve(1'b0, 1'b0, '0);
            exp_mp = sat_inc(exp_mp);
            check("sat_mp_redir", 64'(RedirectPC), 64'h3004 + 64'(i * 16));
            idle();
            idle();
        end
        check_counts("sat_mp");
        check("final_ready", 64'(PredReady), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
